// File: rtl/score_pkg.sv
`default_nettype none
// ============================================================================
// Module   : score_pkg
// Brief    : Shared types and constants for the score controller slice.
// Revision : 1.0  initial release
// ============================================================================
package score_pkg;

    // Score sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        CMP  = 2'd2,
        COPY = 2'd3
    } state_t;

    // One BCD digit, 0-9
    typedef logic [3:0] bcd_digit_t;

    // Off-screen renderer position; the sprite stays blank here
    localparam logic [9:0] PARK_X = 10'd1023;
    localparam logic [8:0] PARK_Y = 9'd511;

endpackage
`default_nettype wire

// File: rtl/score_slot_sel.sv
`default_nettype none
// ============================================================================
// Module   : score_slot_sel
// Brief    : Combinational decoder mapping the next beam column and the
//            current line to a digit slot of the score or hi-score row.
// Revision : 1.0  initial release
// ============================================================================
module score_slot_sel #(
    parameter int DIGITS  = 4,
    parameter int H       = 5,
    parameter int SPACING = 6,
    parameter int SCORE_X = 8,
    parameter int SCORE_Y = 4,
    parameter int HI_X    = 560,
    parameter int HI_Y    = 4,
    parameter int SW      = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic [9:0]    vga_x,
    input  logic [8:0]    vga_y,
    output logic          valid,
    output logic          row,     // 0 = score row, 1 = hi-score row
    output logic [SW-1:0] slot     // 0 = most significant digit
);

    logic [10:0]   w_nx;
    logic          w_in_score;
    logic          w_in_hi;
    logic          w_score_hit;
    logic          w_hi_hit;
    logic [SW-1:0] w_score_slot;
    logic [SW-1:0] w_hi_slot;

    // Lookahead column in 11 bits so vga_x = 1023 does not wrap onto slot 0
    always_comb begin
        w_nx       = {1'b0, vga_x} + 11'd1;
        w_in_score = ({1'b0, vga_y} >= 10'(SCORE_Y)) && ({1'b0, vga_y} < 10'(SCORE_Y + H));
        w_in_hi    = ({1'b0, vga_y} >= 10'(HI_Y))    && ({1'b0, vga_y} < 10'(HI_Y + H));

        w_score_hit  = 1'b0;
        w_score_slot = '0;
        w_hi_hit     = 1'b0;
        w_hi_slot    = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if ((w_nx >= 11'(SCORE_X + i * SPACING)) && (w_nx < 11'(SCORE_X + (i + 1) * SPACING))) begin
                w_score_hit  = 1'b1;
                w_score_slot = SW'(i);
            end
            if ((w_nx >= 11'(HI_X + i * SPACING)) && (w_nx < 11'(HI_X + (i + 1) * SPACING))) begin
                w_hi_hit  = 1'b1;
                w_hi_slot = SW'(i);
            end
        end

        // Score row wins when both rows share the line and x windows collide
        valid = 1'b0;
        row   = 1'b0;
        slot  = '0;
        if (w_in_score && w_score_hit) begin
            valid = 1'b1;
            row   = 1'b0;
            slot  = w_score_slot;
        end else if (w_in_hi && w_hi_hit) begin
            valid = 1'b1;
            row   = 1'b1;
            slot  = w_hi_slot;
        end
    end

endmodule
`default_nettype wire

// File: rtl/score_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : score_ctrl
// Brief    : BCD score / high-score owner with a digit-serial sequencer and a
//            time-multiplexed feed for a single shared digit renderer.
// Revision : 1.0  initial release
// ============================================================================
module score_ctrl
    import score_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int W       = 5,
    parameter int H       = 5,
    parameter int SPACING = 6,
    parameter int SCORE_X = 8,
    parameter int SCORE_Y = 4,
    parameter int HI_X    = 560,
    parameter int HI_Y    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [9:0]          vga_x,
    input  logic [8:0]          vga_y,
    input  logic                add_valid,
    input  logic [3:0]          add_pts,
    output logic                add_ready,
    input  logic                game_over,
    input  logic                new_game,
    output logic                busy,
    output logic [4*DIGITS-1:0] score_bcd,
    output logic [4*DIGITS-1:0] hi_bcd,
    output logic [9:0]          x,
    output logic [8:0]          y,
    output logic [3:0]          num
);

    localparam int            SW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [SW-1:0] C_K_LAST = SW'(DIGITS - 1);

    // Slots must not overlap or touch, otherwise adjacent sprites merge
    if (SPACING <= W) begin : g_bad_spacing
        $error("score_ctrl: SPACING must exceed W");
    end

    state_t        r_state, w_state_nxt;
    logic [SW-1:0] r_k, w_k_nxt;
    logic [3:0]    r_carry, w_carry_nxt;
    bcd_digit_t    r_score [DIGITS];
    bcd_digit_t    r_hi    [DIGITS];

    logic          w_clear, w_sat, w_copy, w_wr;
    logic [4:0]    w_sum;
    bcd_digit_t    w_wr_val, w_sc_k, w_hi_k;

    assign busy      = (r_state != IDLE);
    assign add_ready = (r_state == IDLE);

    // Next-state and datapath controls; new_game aborts from any state
    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_carry_nxt = r_carry;
        w_clear     = 1'b0;
        w_sat       = 1'b0;
        w_copy      = 1'b0;
        w_wr        = 1'b0;
        w_sc_k      = r_score[r_k];
        w_hi_k      = r_hi[r_k];
        w_sum       = {1'b0, w_sc_k} + {1'b0, r_carry};
        w_wr_val    = (w_sum > 5'd9) ? 4'(w_sum - 5'd10) : w_sum[3:0];

        if (new_game) begin
            w_clear     = 1'b1;
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (game_over) begin
                        w_state_nxt = CMP;
                        w_k_nxt     = C_K_LAST;
                    end else if (add_valid) begin
                        w_state_nxt = ADD;
                        w_k_nxt     = '0;
                        w_carry_nxt = (add_pts > 4'd9) ? 4'd9 : add_pts;
                    end
                end
                ADD: begin
                    w_wr = 1'b1;
                    if (w_sum > 5'd9) begin
                        if (r_k == C_K_LAST) begin
                            w_sat       = 1'b1;
                            w_state_nxt = IDLE;
                        end else begin
                            w_k_nxt     = r_k + 1'b1;
                            w_carry_nxt = 4'd1;
                        end
                    end else begin
                        w_carry_nxt = 4'd0;
                        w_state_nxt = IDLE;
                    end
                end
                CMP: begin
                    if (w_sc_k > w_hi_k) begin
                        w_state_nxt = COPY;
                    end else if (w_sc_k < w_hi_k) begin
                        w_state_nxt = IDLE;
                    end else if (r_k == '0) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_k_nxt = r_k - 1'b1;
                    end
                end
                COPY: begin
                    w_copy      = 1'b1;
                    w_state_nxt = IDLE;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Sequencer state, digit index and carry
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_k     <= '0;
            r_carry <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
            r_carry <= w_carry_nxt;
        end
    end

    // Score and high-score digit registers; hi copies all digits at once
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DIGITS; i++) begin
                r_score[i] <= 4'd0;
                r_hi[i]    <= 4'd0;
            end
        end else begin
            if (w_clear) begin
                for (int i = 0; i < DIGITS; i++) r_score[i] <= 4'd0;
            end else if (w_sat) begin
                for (int i = 0; i < DIGITS; i++) r_score[i] <= 4'd9;
            end else if (w_wr) begin
                r_score[r_k] <= w_wr_val;
            end
            if (w_copy) begin
                for (int i = 0; i < DIGITS; i++) r_hi[i] <= r_score[i];
            end
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_pack
        assign score_bcd[4*g +: 4] = r_score[g];
        assign hi_bcd[4*g +: 4]    = r_hi[g];
    end

    logic          w_vld, w_row;
    logic [SW-1:0] w_slot, w_didx;
    logic [9:0]    w_xs;

    score_slot_sel #(
        .DIGITS  (DIGITS),
        .H       (H),
        .SPACING (SPACING),
        .SCORE_X (SCORE_X),
        .SCORE_Y (SCORE_Y),
        .HI_X    (HI_X),
        .HI_Y    (HI_Y),
        .SW      (SW)
    ) u_sel (
        .vga_x (vga_x),
        .vga_y (vga_y),
        .valid (w_vld),
        .row   (w_row),
        .slot  (w_slot)
    );

    // Slot 0 is the MSD, so the digit index counts down from DIGITS-1
    assign w_didx = C_K_LAST - w_slot;
    assign w_xs   = (w_row ? 10'(HI_X) : 10'(SCORE_X)) + 10'(w_slot * SPACING);

    // Renderer feed, registered one pixel ahead of the beam
    always_ff @(posedge clk) begin
        if (reset) begin
            x   <= PARK_X;
            y   <= PARK_Y;
            num <= 4'd0;
        end else if (w_vld) begin
            x   <= w_xs;
            y   <= w_row ? 9'(HI_Y) : 9'(SCORE_Y);
            num <= w_row ? r_hi[w_didx] : r_score[w_didx];
        end else begin
            x   <= PARK_X;
            y   <= PARK_Y;
            num <= 4'd0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_score_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_score_ctrl
// Brief    : Directed self-checking bench for score_ctrl.
// Revision : 1.0  initial release
// ============================================================================
module tb_score_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  vga_x;
    logic [8:0]  vga_y;
    logic        add_valid;
    logic [3:0]  add_pts;
    logic        add_ready;
    logic        game_over;
    logic        new_game;
    logic        busy;
    logic [15:0] score_bcd;
    logic [15:0] hi_bcd;
    logic [9:0]  x;
    logic [8:0]  y;
    logic [3:0]  num;

    int n_tests = 0;
    int n_fail  = 0;

    score_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .vga_x     (vga_x),
        .vga_y     (vga_y),
        .add_valid (add_valid),
        .add_pts   (add_pts),
        .add_ready (add_ready),
        .game_over (game_over),
        .new_game  (new_game),
        .busy      (busy),
        .score_bcd (score_bcd),
        .hi_bcd    (hi_bcd),
        .x         (x),
        .y         (y),
        .num       (num)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_new_game;
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
    endtask

    // Issue one add and report how many cycles the FSM stayed busy afterwards
    task automatic do_add(input int p, output int cyc, output logic ready_low);
        int w;
        w = 0;
        while (!add_ready && w < 50) begin
            tick();
            w++;
        end
        add_valid = 1'b1;
        add_pts   = 4'(p);
        tick();
        add_valid = 1'b0;
        ready_low = !add_ready;
        cyc = 0;
        while (busy && cyc < 50) begin
            tick();
            cyc++;
        end
        if (busy) check_eq("add_timeout", 32'(busy), 32'd0);
    endtask

    task automatic do_game_over(output int cyc);
        game_over = 1'b1;
        tick();
        game_over = 1'b0;
        cyc = 0;
        while (busy && cyc < 50) begin
            tick();
            cyc++;
        end
        if (busy) check_eq("cmp_timeout", 32'(busy), 32'd0);
    endtask

    task automatic set_score(input int v);
        int   rem, p, c;
        logic l;
        pulse_new_game();
        rem = v;
        while (rem > 0) begin
            p = (rem > 9) ? 9 : rem;
            do_add(p, c, l);
            rem -= p;
        end
    endtask

    task automatic check_disp(input string tag, input int vx, input int vy,
                              input int ex, input int ey, input int en);
        vga_x = 10'(vx);
        vga_y = 9'(vy);
        tick();
        check_eq({tag, "_x"},   32'(x),   32'(ex));
        check_eq({tag, "_y"},   32'(y),   32'(ey));
        check_eq({tag, "_num"}, 32'(num), 32'(en));
    endtask

    initial begin
        int   cyc;
        logic rl;

        reset     = 1'b1;
        vga_x     = '0;
        vga_y     = '0;
        add_valid = 1'b0;
        add_pts   = '0;
        game_over = 1'b0;
        new_game  = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        repeat (5) tick();

        check_eq("rst_score", 32'(score_bcd), 32'h0);
        check_eq("rst_hi",    32'(hi_bcd),    32'h0);
        check_eq("rst_busy",  32'(busy),      32'd0);
        check_eq("rst_ready", 32'(add_ready), 32'd1);
        check_eq("rst_x",     32'(x),         32'd1023);
        check_eq("rst_y",     32'(y),         32'd511);
        check_eq("rst_num",   32'(num),       32'd0);

        // 0099 + 3 ripples through two carries
        set_score(99);
        check_eq("s99", 32'(score_bcd), 32'h0099);
        do_add(3, cyc, rl);
        check_eq("add3_ready_low", 32'(rl), 32'd1);
        check_eq("add3_cycles", 32'(cyc), 32'd3);
        check_eq("add3_score", 32'(score_bcd), 32'h0102);

        // Carry out of the MSD saturates
        set_score(9998);
        check_eq("s9998", 32'(score_bcd), 32'h9998);
        do_add(5, cyc, rl);
        check_eq("sat_cycles", 32'(cyc), 32'd4);
        check_eq("sat_score", 32'(score_bcd), 32'h9999);

        // High score updates
        set_score(120);
        do_game_over(cyc);
        check_eq("hi120", 32'(hi_bcd), 32'h0120);
        set_score(125);
        do_game_over(cyc);
        check_eq("go125_cycles", 32'(cyc), 32'd5);
        check_eq("hi125", 32'(hi_bcd), 32'h0125);
        set_score(119);
        do_game_over(cyc);
        check_eq("go119_cycles", 32'(cyc), 32'd3);
        check_eq("hi_kept", 32'(hi_bcd), 32'h0125);

        // new_game aborts an in-flight add on its second cycle
        set_score(999);
        add_valid = 1'b1;
        add_pts   = 4'd1;
        tick();
        add_valid = 1'b0;
        tick();
        check_eq("abort_mid_score", 32'(score_bcd), 32'h0990);
        check_eq("abort_mid_busy",  32'(busy),      32'd1);
        pulse_new_game();
        check_eq("abort_score", 32'(score_bcd), 32'h0);
        check_eq("abort_busy",  32'(busy),      32'd0);
        check_eq("abort_hi",    32'(hi_bcd),    32'h0125);

        // Simultaneous requests: new_game wins, nothing else starts
        do_add(7, cyc, rl);
        check_eq("s7", 32'(score_bcd), 32'h0007);
        new_game  = 1'b1;
        game_over = 1'b1;
        add_valid = 1'b1;
        add_pts   = 4'd3;
        tick();
        new_game  = 1'b0;
        game_over = 1'b0;
        add_valid = 1'b0;
        check_eq("prio_score", 32'(score_bcd), 32'h0);
        check_eq("prio_busy",  32'(busy),      32'd0);

        // Out-of-range points clamp to 9
        do_add(15, cyc, rl);
        check_eq("clamp_score",  32'(score_bcd), 32'h0009);
        check_eq("clamp_cycles", 32'(cyc),       32'd1);

        // Display scheduling
        set_score(1234);
        check_eq("s1234", 32'(score_bcd), 32'h1234);
        check_disp("d_x7",    7,    6, 8,    4,   1);
        check_disp("d_x13",   13,   6, 14,   4,   2);
        check_disp("d_x30",   30,   6, 26,   4,   4);
        check_disp("d_x31",   31,   6, 1023, 511, 0);
        check_disp("d_x40",   40,   6, 1023, 511, 0);
        check_disp("d_hi0",   559,  6, 560,  4,   0);
        check_disp("d_hi1",   565,  6, 566,  4,   1);
        check_disp("d_hi3",   577,  6, 578,  4,   5);
        check_disp("d_x1023", 1023, 6, 1023, 511, 0);
        check_disp("d_y9",    7,    9, 1023, 511, 0);
        check_disp("d_y4",    7,    4, 8,    4,   1);
        check_disp("d_x6",    6,    4, 1023, 511, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
